host_cmd_sequencer: RTL and testbench
=====================================

# host_cmd_sequencer

Upstream front end for the NES core: accepts 16-bit host bus writes carrying our NES opcodes, buffers them in a small command FIFO, and drives the core's CPU control and memory-load signals with correct sequencing. Memory loads never overlap CPU execution. Reset pulses have a guaranteed width. Bounded single-step runs become possible. Sits between the Avalon-style host slave port and the `cpu`/`memory` pair inside `nes`.

## Interface
- `FIFO_DEPTH`, 8: command FIFO entries; power of two, ≥2.
- `RESET_CYCLES`, 4: cycles `cpu_reset` is held per RESET_CPU; ≥1.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high; one clock.
- `chipselect` in 1: host access strobe.
- `write` in 1: host write; qualified by `chipselect`.
- `read` in 1: host read; qualified by `chipselect`.
- `address` in 16: write, target memory address; read, bit0 selects the readback register.
- `writedata` in 16: [15:8] opcode, [7:0] data or count.
- `waitrequest` out 1: high when the FIFO is full; the host must hold the write.
- `readdata` out 8: registered readback.
- `cpu_d_out` in 8: CPU data bus, captured for readback.
- `cpu_reset` out 1: to `cpu.reset`.
- `cpu_ready` out 1: to `cpu.ready`.
- `host_owns_mem` out 1: memory mux select; 1 means the host drives memory.
- `mem_write` out 1: host memory write strobe.
- `mem_addr` out 16: host memory address.
- `mem_in` out 8: host memory write data.

## Operation
- **Push:** `chipselect & write & !waitrequest` pushes {op, address, data}.
- **Pop:** the FSM pops one entry per cycle when in IDLE or RUN and the FIFO is non-empty.
- **Opcodes:**
  - 0 RESET_CPU: go to RESET_HOLD. `cpu_reset`=1 and `cpu_ready`=0 for RESET_CYCLES, then IDLE. Clears `running`.
  - 1 START_CPU: set `running`; go to RUN. `cpu_ready`=1 and `host_owns_mem`=0.
  - 2 PAUSE_CPU: clear `running`; go to IDLE. `cpu_ready`=0.
  - 3 WRITE_MEM: go to MEM_WR for one cycle. `host_owns_mem`=1, `mem_write`=1, `mem_addr`=entry address, `mem_in`=data.
  - 4 SET_PTR: `ptr`←entry address. No output activity.
  - 5 WRITE_INC: MEM_WR at `ptr`, then `ptr`←`ptr`+1. 16-bit wrap: 0xFFFF goes to 0x0000.
  - 6 STEP: go to STEP. `cpu_ready`=1 for N cycles, where N=data and 0 means 256. Then back to IDLE, or RUN if `running`.
- **Memory write while running:** `cpu_ready` drops to 0 during the MEM_WR cycle, then returns to RUN. The CPU loses exactly one cycle.
- **Unknown opcode (≥7):** consumed as a no-op; sets sticky `err`.
- **FSM states:** IDLE, RUN, RESET_HOLD, MEM_WR, STEP. No pops in RESET_HOLD, MEM_WR or STEP.
- **Readback:** a host read sets `readdata` next cycle.
  - `address[0]`=0 returns status {3'b0, err, running, busy, fifo_full, fifo_empty}.
  - `address[0]`=1 returns the `cpu_d_out` value captured on the last cycle with `cpu_ready`=1.
  - A status read clears `err` on the same edge that loads `readdata`.
- `busy` = state ∉ {IDLE, RUN} or FIFO non-empty.

## Timing
- **Reset values:** all outputs 0, including `waitrequest`, `readdata`, `cpu_reset`, `cpu_ready`, `host_owns_mem`, `mem_write`, `mem_addr` and `mem_in`. FIFO empty, `ptr`=0, `err`=0, `running`=0, state IDLE.
- **Latency:** a write pushed at edge N is popped at N+1 (FIFO was empty, FSM in IDLE/RUN). Its registered outputs are visible after edge N+2.
- **Outputs:** all registered, no combinational host-to-core paths.
- **`waitrequest`:** registered full flag. Set on the edge where the count reaches FIFO_DEPTH; cleared the edge after a pop.
- **Push and pop in the same cycle:** count unchanged. A push into an empty FIFO is not popped in the same cycle.
- **Reset mid-operation** (RESET_HOLD, STEP, MEM_WR): FSM to IDLE, FIFO flushed, remaining counts discarded.
- **Back-to-back RESET_CPU:** the second reset restarts the full RESET_CYCLES count after the first finishes. Pulses are never merged.
- **Counter widths:** the STEP counter is 9 bits; the reset counter is `$clog2(RESET_CYCLES+1)` bits.

## Structure
- **`nes_pkg`:** opcode enum `nes_op_t` (RESET_CPU … STEP), FSM enum `seq_state_t`, packed `cmd_t` {op[7:0], addr[15:0], data[7:0]}. `nes` imports the same opcode constants.
- **Sub-module `cmd_fifo`:** synchronous FIFO parameterized on depth and `cmd_t`; outputs full, empty, count.
- **Sequencer FSM, `ptr`, counters and readback** live in `host_cmd_sequencer`.

## Test plan
- **Reset then START_CPU:** after `reset`, write 0x0000 → `cpu_reset` high for exactly 4 cycles, `cpu_ready` 0. Then write 0x0100 → `cpu_ready`=1 two cycles after acceptance.
- **Auto-increment load:** SET_PTR to 0xFFFE (writedata 0x0400), then WRITE_INC with data 0xA9, 0x01, 0x8D → memory writes at 0xFFFE, 0xFFFF, 0x0000; `host_owns_mem`=1 on each.
- **Backpressure:** 9 writes with `cpu_ready` paused and the FSM held in STEP → `waitrequest` asserts on the 9th. The write completes after the first pop; no entry is lost or duplicated.
- **STEP:** writedata 0x0603 → `cpu_ready` high for exactly 3 cycles. Writedata 0x0600 → high for exactly 256 cycles.
- **Write while running:** START, then WRITE_MEM addr 0x0200 data 0x55 → one cycle with `cpu_ready`=0 and `mem_write`=1, then `cpu_ready`=1 resumes.
- **Error and mid-run reset:** opcode 0x09 → status bit4=1 on the first read, 0 on the second. Asserting `reset` during STEP → all outputs 0 and status 0x01 next read.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared types for the NES host command path: opcodes, sequencer states and
// the command word that travels through the command FIFO.
package nes_pkg;

  // Host opcodes carried in writedata[15:8]
  typedef enum logic [7:0] {
    OP_RESET_CPU = 8'd0,
    OP_START_CPU = 8'd1,
    OP_PAUSE_CPU = 8'd2,
    OP_WRITE_MEM = 8'd3,
    OP_SET_PTR   = 8'd4,
    OP_WRITE_INC = 8'd5,
    OP_STEP      = 8'd6
  } nes_op_t;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_RESET_HOLD,
    S_MEM_WR,
    S_STEP
  } seq_state_t;

  // One buffered host write
  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_t;

  // Step counter preload: N cycles of cpu_ready means load N-1; N=0 means 256
  function automatic logic [8:0] step_load(input logic [7:0] n);
    return (n == 8'd0) ? 9'd255 : ({1'b0, n} - 9'd1);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags and an
// occupancy count. Read data is the head entry, valid whenever !empty.
module cmd_fifo
  import nes_pkg::*;
#(
  parameter int  DEPTH  = 8,
  parameter type data_t = cmd_t
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  data_t                      wr_data,
  input  logic                       pop,
  output data_t                      rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  data_t          mem [DEPTH];
  logic  [AW-1:0] wr_ptr;
  logic  [AW-1:0] rd_ptr;
  logic  [CW-1:0] count_next;
  logic           do_push;
  logic           do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Next occupancy; a simultaneous push and pop leaves it unchanged
  always_comb begin
    // NOTE: the default assignment first means every path assigns count_next, so no latch is inferred.
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Pointers, count and flags; flags are registered from the next count
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register update on the same edge, independent of statement order.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers and count decide which entries are valid.
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/host_cmd_sequencer.sv
// Host-to-core command sequencer: buffers host writes in a FIFO, stages the
// head command in a register, and runs an FSM that drives CPU control and the
// host memory-load port. All core-facing outputs and readdata are registered.
module host_cmd_sequencer
  import nes_pkg::*;
#(
  parameter int FIFO_DEPTH   = 8,
  parameter int RESET_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic [15:0] address,
  input  logic [15:0] writedata,
  output logic        waitrequest,
  output logic [7:0]  readdata,
  input  logic [7:0]  cpu_d_out,
  output logic        cpu_reset,
  output logic        cpu_ready,
  output logic        host_owns_mem,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_in
);

  localparam int RCW = $clog2(RESET_CYCLES + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam logic [RCW-1:0] RST_LOAD = RCW'(RESET_CYCLES - 1);

  seq_state_t     state;
  cmd_t           fifo_out;
  cmd_t           cmd_q;
  logic           cmd_valid;
  logic           fifo_full;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;
  logic           push;
  logic           pop;
  logic           can_issue;
  logic           exec;
  logic           running;
  logic           err;
  logic           err_set;
  logic           status_rd;
  logic           busy;
  logic [15:0]    ptr;
  logic [RCW-1:0] rst_cnt;
  logic [8:0]     step_cnt;
  logic [7:0]     d_cap;
  logic [7:0]     status;

  assign waitrequest = fifo_full;
  assign push        = chipselect && write && !waitrequest;
  assign can_issue   = (state == S_IDLE) || (state == S_RUN);
  assign pop         = can_issue && !fifo_empty;
  assign exec        = can_issue && cmd_valid;
  assign err_set     = exec && (cmd_q.op > OP_STEP);
  assign status_rd   = chipselect && read && !address[0];
  assign busy        = !can_issue || (fifo_count != '0) || cmd_valid;
  assign status      = {3'b000, err, running, busy, fifo_full, fifo_empty};

  cmd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .data_t (cmd_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data ('{op: writedata[15:8], addr: address, data: writedata[7:0]}),
    .pop     (pop),
    .rd_data (fifo_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Stage the popped head; it is consumed on the next IDLE/RUN cycle and held otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q     <= '0;
      cmd_valid <= 1'b0;
    end else if (pop) begin
      cmd_q     <= fifo_out;
      cmd_valid <= 1'b1;
    end else if (can_issue) begin
      cmd_valid <= 1'b0;
    end
  end

  // Sequencer FSM with registered CPU/memory outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      running       <= 1'b0;
      ptr           <= '0;
      rst_cnt       <= '0;
      step_cnt      <= '0;
      cpu_reset     <= 1'b0;
      cpu_ready     <= 1'b0;
      host_owns_mem <= 1'b0;
      mem_write     <= 1'b0;
      mem_addr      <= '0;
      mem_in        <= '0;
    end else begin
      case (state)
        S_IDLE, S_RUN: begin
          if (exec) begin
            case (cmd_q.op)
              OP_RESET_CPU: begin
                state     <= S_RESET_HOLD;
                running   <= 1'b0;
                cpu_reset <= 1'b1;
                cpu_ready <= 1'b0;
                rst_cnt   <= RST_LOAD;
              end
              OP_START_CPU: begin
                state         <= S_RUN;
                running       <= 1'b1;
                cpu_ready     <= 1'b1;
                host_owns_mem <= 1'b0;
              end
              OP_PAUSE_CPU: begin
                state     <= S_IDLE;
                running   <= 1'b0;
                cpu_ready <= 1'b0;
              end
              OP_WRITE_MEM: begin
                state         <= S_MEM_WR;
                cpu_ready     <= 1'b0;
                host_owns_mem <= 1'b1;
                mem_write     <= 1'b1;
                mem_addr      <= cmd_q.addr;
                mem_in        <= cmd_q.data;
              end
              OP_SET_PTR: begin
                ptr <= cmd_q.addr;
              end
              OP_WRITE_INC: begin
                state         <= S_MEM_WR;
                cpu_ready     <= 1'b0;
                host_owns_mem <= 1'b1;
                mem_write     <= 1'b1;
                mem_addr      <= ptr;
                mem_in        <= cmd_q.data;
                ptr           <= ptr + 16'd1;
              end
              OP_STEP: begin
                state     <= S_STEP;
                cpu_ready <= 1'b1;
                step_cnt  <= step_load(cmd_q.data);
              end
              default: ; // unknown opcode: consumed, flagged via err_set
            endcase
          end
        end
        S_RESET_HOLD: begin
          if (rst_cnt == '0) begin
            state     <= S_IDLE;
            cpu_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt - RCW'(1);
          end
        end
        S_MEM_WR: begin
          state         <= running ? S_RUN : S_IDLE;
          cpu_ready     <= running;
          host_owns_mem <= 1'b0;
          mem_write     <= 1'b0;
        end
        S_STEP: begin
          if (step_cnt == 9'd0) begin
            state     <= running ? S_RUN : S_IDLE;
            cpu_ready <= running;
          end else begin
            step_cnt <= step_cnt - 9'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky error flag; a new error wins over a clearing status read on the same edge
  always_ff @(posedge clk) begin
    if (reset)          err <= 1'b0;
    else if (err_set)   err <= 1'b1;
    else if (status_rd) err <= 1'b0;
  end

  // Host readback and capture of the CPU data bus while the CPU is clocked
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      d_cap    <= '0;
    end else begin
      if (cpu_ready) d_cap <= cpu_d_out;
      if (chipselect && read) readdata <= address[0] ? d_cap : status;
    end
  end

endmodule

// File: tb/tb_host_cmd_sequencer.sv
// Scoreboard bench for host_cmd_sequencer: the stimulus thread pushes expected
// memory writes, reset/ready pulse widths and readback values into queues;
// independent monitors pop and compare whenever the DUT presents them.
module tb_host_cmd_sequencer;
  import nes_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [15:0] address;
  logic [15:0] writedata;
  logic        waitrequest;
  logic [7:0]  readdata;
  logic [7:0]  cpu_d_out;
  logic        cpu_reset;
  logic        cpu_ready;
  logic        host_owns_mem;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [7:0]  mem_in;

  always #5 clk = ~clk;

  host_cmd_sequencer #(
    .FIFO_DEPTH   (8),
    .RESET_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .chipselect    (chipselect),
    .write         (write),
    .read          (read),
    .address       (address),
    .writedata     (writedata),
    .waitrequest   (waitrequest),
    .readdata      (readdata),
    .cpu_d_out     (cpu_d_out),
    .cpu_reset     (cpu_reset),
    .cpu_ready     (cpu_ready),
    .host_owns_mem (host_owns_mem),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_in        (mem_in)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        ready_after;
  } mem_exp_t;

  int         checks = 0;
  int         errors = 0;
  mem_exp_t   mem_q[$];
  int         rst_q[$];
  int         rdy_q[$];
  logic [7:0] rd_q[$];
  bit         track_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got a DUT event expected none", name);
  endtask

  // Memory-write monitor
  initial begin : mem_mon
    mem_exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && mem_write) begin
        if (mem_q.size() == 0) unexpected("mem_write");
        else begin
          e = mem_q.pop_front();
          check("mem_addr", 64'(mem_addr), 64'(e.addr));
          check("mem_in", 64'(mem_in), 64'(e.data));
          check("mem_owner", 64'(host_owns_mem), 64'd1);
          check("mem_ready_low", 64'(cpu_ready), 64'd0);
          @(negedge clk);
          check("mem_ready_after", 64'(cpu_ready), 64'(e.ready_after));
        end
      end
    end
  end

  // cpu_reset pulse-width monitor
  initial begin : rst_mon
    int len;
    bit saw_ready;
    len = 0;
    saw_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        len = 0;
        saw_ready = 1'b0;
      end else if (cpu_reset) begin
        len++;
        if (cpu_ready) saw_ready = 1'b1;
      end else if (len > 0) begin
        if (rst_q.size() == 0) unexpected("cpu_reset_pulse");
        else check("rst_width", 64'(len), 64'(rst_q.pop_front()));
        check("rst_ready_low", 64'(saw_ready), 64'd0);
        len = 0;
        saw_ready = 1'b0;
      end
    end
  end

  // cpu_ready pulse-width monitor (only while step pulses are being tracked)
  initial begin : rdy_mon
    int len;
    len = 0;
    forever begin
      @(negedge clk);
      if (reset) len = 0;
      else if (cpu_ready) len++;
      else if (len > 0) begin
        if (track_ready) begin
          if (rdy_q.size() == 0) unexpected("cpu_ready_pulse");
          else check("ready_width", 64'(len), 64'(rdy_q.pop_front()));
        end
        len = 0;
      end
    end
  end

  // Readback monitor: readdata is valid the cycle after a read strobe
  initial begin : rd_mon
    logic [7:0] e;
    forever begin
      @(posedge clk);
      if (!reset && chipselect && read) begin
        @(negedge clk);
        if (rd_q.size() == 0) unexpected("readdata");
        else begin
          e = rd_q.pop_front();
          check("readdata", 64'(readdata), 64'(e));
        end
      end
    end
  end

  task automatic host_write(input logic [15:0] a, input logic [15:0] wd, output int stall);
    stall = 0;
    @(negedge clk);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = wd;
    while (waitrequest && stall < 2000) begin
      @(negedge clk);
      stall++;
    end
    if (waitrequest) unexpected("write_timeout");
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] wd);
    int s;
    host_write(a, wd, s);
  endtask

  task automatic host_read(input logic a0, input logic [7:0] exp);
    @(negedge clk);
    rd_q.push_back(exp);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = {15'h0000, a0};
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read       = 1'b0;
  endtask

  task automatic wait_ready(input int bound);
    int n;
    n = 0;
    while (!cpu_ready && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", 64'(cpu_ready), 64'd1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {27'h0, waitrequest, readdata, cpu_reset, cpu_ready, host_owns_mem,
                 mem_write, mem_addr, mem_in}, 64'd0);
  endtask

  initial begin : stim
    int st;
    int early;
    int last;
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    address    = '0;
    writedata  = '0;
    cpu_d_out  = 8'h3C;
    reset      = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    @(negedge clk);
    reset = 1'b0;
    host_read(1'b0, 8'h01);

    // RESET_CPU pulse width
    rst_q.push_back(4);
    wr(16'h0000, 16'h0000);
    repeat (10) @(posedge clk);

    // START_CPU latency: ready visible two edges after acceptance
    wr(16'h0000, 16'h0100);
    @(posedge clk); #1;
    check("start_lat_edge1", 64'(cpu_ready), 64'd0);
    @(posedge clk); #1;
    check("start_lat_edge2", 64'(cpu_ready), 64'd1);
    check("run_host_owner", 64'(host_owns_mem), 64'd0);
    host_read(1'b0, 8'h09);

    // Memory write while running costs the CPU exactly one cycle
    mem_q.push_back('{addr: 16'h0200, data: 8'h55, ready_after: 1'b1});
    wr(16'h0200, 16'h0355);
    repeat (10) @(posedge clk);

    // PAUSE
    wr(16'h0000, 16'h0200);
    repeat (5) @(posedge clk); #1;
    check("pause_ready", 64'(cpu_ready), 64'd0);

    // Auto-increment load across the 16-bit wrap
    mem_q.push_back('{addr: 16'hFFFE, data: 8'hA9, ready_after: 1'b0});
    mem_q.push_back('{addr: 16'hFFFF, data: 8'h01, ready_after: 1'b0});
    mem_q.push_back('{addr: 16'h0000, data: 8'h8D, ready_after: 1'b0});
    wr(16'hFFFE, 16'h0400);
    wr(16'h0000, 16'h05A9);
    wr(16'h0000, 16'h0501);
    wr(16'h0000, 16'h058D);
    repeat (20) @(posedge clk);

    // STEP 3, CPU data capture, STEP 256
    track_ready = 1'b1;
    rdy_q.push_back(3);
    wr(16'h0000, 16'h0603);
    repeat (10) @(posedge clk);
    cpu_d_out = 8'hC3;
    host_read(1'b1, 8'h3C);
    rdy_q.push_back(256);
    wr(16'h0000, 16'h0600);
    repeat (270) @(posedge clk);
    track_ready = 1'b0;

    // Back-to-back RESET_CPU: two separate full-width pulses
    rst_q.push_back(4);
    rst_q.push_back(4);
    wr(16'h0000, 16'h0000);
    wr(16'h0000, 16'h0000);
    repeat (20) @(posedge clk);

    // Unknown opcode sets sticky err; a status read clears it
    wr(16'h0000, 16'h0900);
    repeat (5) @(posedge clk);
    host_read(1'b0, 8'h11);
    host_read(1'b0, 8'h01);

    // Backpressure with the FSM held in STEP
    track_ready = 1'b1;
    rdy_q.push_back(256);
    wr(16'h0000, 16'h0600);
    wait_ready(50);
    early = 0;
    last  = 0;
    for (int i = 0; i < 9; i++) begin
      mem_q.push_back('{addr: 16'(16'h1000 + i), data: 8'(8'h10 + i), ready_after: 1'b0});
      host_write(16'(16'h1000 + i), {8'h03, 8'(8'h10 + i)}, st);
      if (i < 8) early += st;
      else       last = st;
    end
    check("bp_first8_no_stall", 64'(early), 64'd0);
    check("bp_ninth_stalled", 64'(last > 0), 64'd1);
    repeat (40) @(posedge clk);
    track_ready = 1'b0;
    host_read(1'b0, 8'h01);

    // Reset during STEP with queued commands: everything discarded
    wr(16'h0000, 16'h0600);
    wait_ready(50);
    wr(16'h3000, 16'h0377);
    wr(16'h3001, 16'h0388);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_all_zero("midrun_reset_outputs");
    @(negedge clk);
    reset = 1'b0;
    host_read(1'b0, 8'h01);
    repeat (30) @(posedge clk); #1;
    check("midrun_ready_stays_low", 64'(cpu_ready), 64'd0);

    // Every expected event was observed
    check("mem_q_drained", 64'(mem_q.size()), 64'd0);
    check("rst_q_drained", 64'(rst_q.size()), 64'd0);
    check("rdy_q_drained", 64'(rdy_q.size()), 64'd0);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
